// File: rtl/router.sv
// Five-port wormhole mesh router: per-input flit FIFOs, XY routing on headers,
// per-output round-robin arbitration and output locking until the packet tail.
module router #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  routeridx,
  input  logic [1:0]  routeridy,
  input  logic [31:0] north_in,
  input  logic [31:0] south_in,
  input  logic [31:0] east_in,
  input  logic [31:0] west_in,
  input  logic [31:0] local_in,
  input  logic        push_north,
  input  logic        push_south,
  input  logic        push_east,
  input  logic        push_west,
  input  logic        push_local,
  input  logic [2:0]  count_in_north,
  input  logic [2:0]  count_in_south,
  input  logic [2:0]  count_in_east,
  input  logic [2:0]  count_in_west,
  input  logic [2:0]  count_in_local,
  output logic [31:0] north_out,
  output logic [31:0] south_out,
  output logic [31:0] east_out,
  output logic [31:0] west_out,
  output logic [31:0] local_out,
  output logic [2:0]  count_out_north,
  output logic [2:0]  count_out_south,
  output logic [2:0]  count_out_east,
  output logic [2:0]  count_out_west,
  output logic [2:0]  count_out_local,
  output logic        pop_north,
  output logic        pop_south,
  output logic        pop_east,
  output logic        pop_west,
  output logic        pop_local
);

  localparam int unsigned NP = 5;
  localparam int unsigned FW = 32;
  localparam int unsigned CW = 3;
  localparam int unsigned IW = 3;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [IW-1:0] P_N = 3'd0;
  localparam logic [IW-1:0] P_S = 3'd1;
  localparam logic [IW-1:0] P_E = 3'd2;
  localparam logic [IW-1:0] P_W = 3'd3;
  localparam logic [IW-1:0] P_L = 3'd4;

  localparam logic [1:0] F_IDLE = 2'b00;
  localparam logic [1:0] F_HEAD = 2'b01;
  localparam logic [1:0] F_BODY = 2'b10;
  localparam logic [1:0] F_TAIL = 2'b11;

  logic [FW-1:0] in_w   [NP];
  logic [CW-1:0] cin_w  [NP];
  logic [NP-1:0] push_w;

  logic [FW-1:0] mem_q      [NP][DEPTH];
  logic [PW-1:0] rd_q       [NP];
  logic [PW-1:0] rd_d       [NP];
  logic [PW-1:0] wr_q       [NP];
  logic [PW-1:0] wr_d       [NP];
  logic [CW-1:0] cnt_q      [NP];
  logic [CW-1:0] cnt_d      [NP];
  logic [IW-1:0] lock_src_q [NP];
  logic [IW-1:0] lock_src_d [NP];
  logic [IW-1:0] rr_q       [NP];
  logic [IW-1:0] rr_d       [NP];
  logic [FW-1:0] out_q      [NP];
  logic [FW-1:0] out_d      [NP];
  logic [NP-1:0] lock_vld_q, lock_vld_d;
  logic [NP-1:0] pop_q, pop_d;
  logic [NP-1:0] wr_en;

  logic [FW-1:0] head      [NP];
  logic [IW-1:0] req_port  [NP];
  logic [NP-1:0] nonempty;
  logic [NP-1:0] locked_in;
  logic [NP-1:0] room;

  assign in_w[0] = north_in;
  assign in_w[1] = south_in;
  assign in_w[2] = east_in;
  assign in_w[3] = west_in;
  assign in_w[4] = local_in;
  assign cin_w[0] = count_in_north;
  assign cin_w[1] = count_in_south;
  assign cin_w[2] = count_in_east;
  assign cin_w[3] = count_in_west;
  assign cin_w[4] = count_in_local;
  assign push_w = {push_local, push_west, push_east, push_south, push_north};

  assign north_out = out_q[P_N];
  assign south_out = out_q[P_S];
  assign east_out  = out_q[P_E];
  assign west_out  = out_q[P_W];
  assign local_out = out_q[P_L];
  assign count_out_north = cnt_q[P_N];
  assign count_out_south = cnt_q[P_S];
  assign count_out_east  = cnt_q[P_E];
  assign count_out_west  = cnt_q[P_W];
  assign count_out_local = cnt_q[P_L];
  assign {pop_local, pop_west, pop_east, pop_south, pop_north} = pop_q;

  // Dimension-ordered routing: resolve X first, then Y, then deliver locally.
  function automatic logic [IW-1:0] xy_route(input logic [1:0] dx, input logic [1:0] dy,
                                             input logic [1:0] ix, input logic [1:0] iy);
    logic [IW-1:0] p;
    if (dx > ix)      p = P_E;
    else if (dx < ix) p = P_W;
    else if (dy > iy) p = P_N;
    else if (dy < iy) p = P_S;
    else              p = P_L;
    return p;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // An input already holding an output lock follows that lock instead of routing.
  always_comb begin
    for (int unsigned i = 0; i < NP; i++) begin
      head[i]      = mem_q[i][rd_q[i]];
      nonempty[i]  = (cnt_q[i] != '0);
      room[i]      = (cin_w[i] < CW'(DEPTH));
      locked_in[i] = 1'b0;
      req_port[i]  = xy_route(head[i][23:22], head[i][21:20], routeridx, routeridy);
      for (int unsigned o = 0; o < NP; o++) begin
        if (lock_vld_q[o] && (lock_src_q[o] == IW'(i))) begin
          locked_in[i] = 1'b1;
          req_port[i]  = IW'(o);
        end
      end
    end
  end

  always_comb begin : arb
    logic          found;
    logic [IW-1:0] win;
    logic [IW-1:0] src;
    int unsigned   c;
    found      = 1'b0;
    win        = '0;
    src        = '0;
    c          = 0;
    pop_d      = '0;
    lock_vld_d = lock_vld_q;
    for (int unsigned o = 0; o < NP; o++) begin
      out_d[o]      = '0;
      lock_src_d[o] = lock_src_q[o];
      rr_d[o]       = rr_q[o];
    end

    for (int unsigned o = 0; o < NP; o++) begin
      if (lock_vld_q[o]) begin
        src = lock_src_q[o];
        if (nonempty[src] && room[o]) begin
          out_d[o]   = head[src];
          pop_d[src] = 1'b1;
          if (head[src][31:30] == F_TAIL) lock_vld_d[o] = 1'b0;
        end
      end else begin
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 0; k < NP; k++) begin
          c = 32'(rr_q[o]) + k;
          if (c >= NP) c = c - NP;
          if (!found && nonempty[c] && !locked_in[c] && (head[c][31:30] == F_HEAD) &&
              (req_port[c] == IW'(o))) begin
            found = 1'b1;
            win   = IW'(c);
          end
        end
        if (found && room[o]) begin
          out_d[o]      = head[win];
          pop_d[win]    = 1'b1;
          lock_vld_d[o] = 1'b1;
          lock_src_d[o] = win;
          rr_d[o]       = (win == IW'(NP - 1)) ? '0 : win + IW'(1);
        end
      end
    end

    // Orphan body/tail flits (no lock owning their input) are dropped.
    for (int unsigned i = 0; i < NP; i++) begin
      if (nonempty[i] && !locked_in[i] &&
          ((head[i][31:30] == F_BODY) || (head[i][31:30] == F_TAIL)))
        pop_d[i] = 1'b1;
    end

    if (!enable) begin
      pop_d      = '0;
      lock_vld_d = lock_vld_q;
      for (int unsigned o = 0; o < NP; o++) begin
        out_d[o]      = out_q[o];
        lock_src_d[o] = lock_src_q[o];
        rr_d[o]       = rr_q[o];
      end
    end
  end

  // A full FIFO still accepts a write when its head leaves in the same cycle.
  always_comb begin
    for (int unsigned i = 0; i < NP; i++) begin
      wr_en[i] = enable && push_w[i] && (in_w[i][31:30] != F_IDLE) &&
                 ((cnt_q[i] < CW'(DEPTH)) || pop_d[i]);
      rd_d[i]  = pop_d[i] ? ptr_inc(rd_q[i]) : rd_q[i];
      wr_d[i]  = wr_en[i] ? ptr_inc(wr_q[i]) : wr_q[i];
      cnt_d[i] = cnt_q[i];
      if (wr_en[i] && !pop_d[i])      cnt_d[i] = cnt_q[i] + CW'(1);
      else if (!wr_en[i] && pop_d[i]) cnt_d[i] = cnt_q[i] - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NP; i++) begin
        rd_q[i]       <= '0;
        wr_q[i]       <= '0;
        cnt_q[i]      <= '0;
        lock_src_q[i] <= '0;
        rr_q[i]       <= '0;
        out_q[i]      <= '0;
      end
      lock_vld_q <= '0;
      pop_q      <= '0;
    end else begin
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      lock_src_q <= lock_src_d;
      rr_q       <= rr_d;
      out_q      <= out_d;
      lock_vld_q <= lock_vld_d;
      pop_q      <= pop_d;
    end
  end

  // Storage needs no reset: occupancy counters gate every read.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NP; i++) begin
      if (wr_en[i]) mem_q[i][wr_q[i]] <= in_w[i];
    end
  end

endmodule

// File: tb/tb_router.sv
// Self-checking bench for router: routing vector table, wormhole/arbitration
// sequences and a flit scoreboard checked whenever an output carries data.
module tb_router;

  localparam int NP = 5;
  localparam int PN = 0, PS = 1, PE = 2, PW = 3, PL = 4;

  typedef struct packed {
    logic [2:0]  port;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [1:0]  x;
    logic [1:0]  y;
    logic [31:0] flit;
    int          port;
  } vec_t;

  logic clk = 1'b0;
  logic reset, enable;
  logic [1:0] idx, idy;
  logic [NP-1:0][31:0] din;
  logic [NP-1:0]       push;
  logic [NP-1:0][2:0]  cin;
  logic [NP-1:0][31:0] dout;
  logic [NP-1:0][2:0]  cout;
  logic [NP-1:0]       pop;

  int tests = 0;
  int fails = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  router #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .routeridx(idx), .routeridy(idy),
    .north_in(din[PN]), .south_in(din[PS]), .east_in(din[PE]), .west_in(din[PW]), .local_in(din[PL]),
    .push_north(push[PN]), .push_south(push[PS]), .push_east(push[PE]), .push_west(push[PW]),
    .push_local(push[PL]),
    .count_in_north(cin[PN]), .count_in_south(cin[PS]), .count_in_east(cin[PE]),
    .count_in_west(cin[PW]), .count_in_local(cin[PL]),
    .north_out(dout[PN]), .south_out(dout[PS]), .east_out(dout[PE]), .west_out(dout[PW]),
    .local_out(dout[PL]),
    .count_out_north(cout[PN]), .count_out_south(cout[PS]), .count_out_east(cout[PE]),
    .count_out_west(cout[PW]), .count_out_local(cout[PL]),
    .pop_north(pop[PN]), .pop_south(pop[PS]), .pop_east(pop[PE]), .pop_west(pop[PW]),
    .pop_local(pop[PL])
  );

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_add(input int port, input logic [31:0] d);
    exp_t e;
    e.port = 3'(port);
    e.data = d;
    sbq.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    for (int o = 0; o < NP; o++) begin
      if (dout[o] != '0) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected port %0d: got %0h expected no flit", o, dout[o]);
        end else begin
          e = sbq.pop_front();
          check($sformatf("sb_port%0d", o), 160'(o), 160'(e.port));
          check($sformatf("sb_data%0d", o), 160'(dout[o]), 160'(e.data));
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic clear_in();
    push = '0;
    din  = '0;
  endtask

  task automatic do_reset(input logic [1:0] x, input logic [1:0] y);
    reset  = 1'b1;
    enable = 1'b1;
    clear_in();
    cin = '0;
    idx = x;
    idy = y;
    #2;
    sbq.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic sb_drained(input string name);
    check(name, 160'(sbq.size()), 160'(0));
  endtask

  vec_t vt[7];
  logic [NP-1:0][31:0] exp_vec;
  logic [31:0] nseq[6];
  logic [31:0] lseq[3];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; idx = '0; idy = '0;
    din = '0; push = '0; cin = '0;

    // Reset state and single-header latency at (0,0).
    do_reset(2'd0, 2'd0);
    check("rst_out", 160'(dout), 160'(0));
    check("rst_cnt", 160'(cout), 160'(0));
    check("rst_pop", 160'(pop), 160'(0));
    din[PL] = 32'h4350_0025; push[PL] = 1'b1;
    sb_add(PE, 32'h4350_0025);
    tick();
    clear_in();
    check("lat_cnt1", 160'(cout[PL]), 160'(1));
    check("lat_east0", 160'(dout[PE]), 160'(0));
    tick();
    check("lat_east", 160'(dout[PE]), 160'(32'h4350_0025));
    check("lat_pop", 160'(pop[PL]), 160'(1));
    check("lat_cnt0", 160'(cout[PL]), 160'(0));
    tick();
    check("lat_pop_end", 160'(pop[PL]), 160'(0));
    check("lat_east_idle", 160'(dout[PE]), 160'(0));
    sb_drained("lat_sb");

    // XY routing table: {router x, router y, header, expected output}.
    vt[0] = '{2'd0, 2'd0, 32'h4350_0025, PE};
    vt[1] = '{2'd1, 2'd0, 32'h4310_0025, PW};
    vt[2] = '{2'd0, 2'd0, 32'h4310_0025, PN};
    vt[3] = '{2'd1, 2'd1, 32'h4350_0025, PL};
    vt[4] = '{2'd1, 2'd1, 32'h4340_0000, PS};
    vt[5] = '{2'd2, 2'd2, 32'h40C0_0001, PE};
    vt[6] = '{2'd2, 2'd1, 32'h4030_0000, PW};
    for (int v = 0; v < 7; v++) begin
      do_reset(vt[v].x, vt[v].y);
      sb_add(vt[v].port, vt[v].flit);
      din[PL] = vt[v].flit; push[PL] = 1'b1;
      tick();
      clear_in();
      tick();
      exp_vec = '0;
      exp_vec[vt[v].port] = vt[v].flit;
      check($sformatf("route%0d", v), 160'(dout), 160'(exp_vec));
      tick();
      sb_drained($sformatf("route%0d_sb", v));
    end

    // Three-flit packet streams back to back; lock frees after the tail.
    do_reset(2'd0, 2'd0);
    sb_add(PE, 32'h4350_0025); sb_add(PE, 32'h8888_8822); sb_add(PE, 32'hC030_0024);
    din[PL] = 32'h4350_0025; push[PL] = 1'b1;
    tick();
    din[PL] = 32'h8888_8822;
    tick();
    check("pkt_head", 160'(dout[PE]), 160'(32'h4350_0025));
    din[PL] = 32'hC030_0024;
    tick();
    check("pkt_body", 160'(dout[PE]), 160'(32'h8888_8822));
    clear_in();
    tick();
    check("pkt_tail", 160'(dout[PE]), 160'(32'hC030_0024));
    tick();
    check("pkt_idle", 160'(dout[PE]), 160'(0));
    sb_add(PE, 32'h4350_0077);
    din[PN] = 32'h4350_0077; push[PN] = 1'b1;
    tick();
    clear_in();
    tick();
    check("pkt_relock", 160'(dout[PE]), 160'(32'h4350_0077));
    sb_drained("pkt_sb");

    // North and local contend for east; north sends a second packet that must
    // lose the next contention to local.
    do_reset(2'd0, 2'd0);
    nseq = '{32'h4350_00A1, 32'h8000_00A2, 32'hC000_00A3,
             32'h4350_00C1, 32'h8000_00C2, 32'hC000_00C3};
    lseq = '{32'h4350_00B1, 32'h8000_00B2, 32'hC000_00B3};
    for (int i = 0; i < 3; i++) sb_add(PE, nseq[i]);
    for (int i = 0; i < 3; i++) sb_add(PE, lseq[i]);
    for (int i = 3; i < 6; i++) sb_add(PE, nseq[i]);
    for (int i = 0; i < 6; i++) begin
      din[PN] = nseq[i]; push[PN] = 1'b1;
      if (i < 3) begin
        din[PL] = lseq[i]; push[PL] = 1'b1;
      end else begin
        din[PL] = '0; push[PL] = 1'b0;
      end
      tick();
    end
    clear_in();
    for (int i = 0; i < 8; i++) tick();
    sb_drained("arb_sb");

    // Downstream full: FIFO saturates at 4, extra flits drop, then drain.
    do_reset(2'd0, 2'd0);
    cin[PE] = 3'd4;
    for (int i = 0; i < 6; i++) begin
      din[PL] = (i == 0) ? 32'h4350_0001 : (32'h8000_0001 + 32'(i));
      push[PL] = 1'b1;
      if (i < 4) sb_add(PE, din[PL]);
      tick();
    end
    clear_in();
    check("full_cnt", 160'(cout[PL]), 160'(4));
    check("full_east", 160'(dout[PE]), 160'(0));
    check("full_pop", 160'(pop[PL]), 160'(0));
    cin[PE] = 3'd0;
    for (int i = 0; i < 6; i++) tick();
    check("drain_cnt", 160'(cout[PL]), 160'(0));
    sb_drained("drain_sb");

    // Enable low freezes the FIFO and suppresses pops.
    do_reset(2'd0, 2'd0);
    din[PL] = 32'h4350_0042; push[PL] = 1'b1;
    tick();
    clear_in();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("dis_cnt", 160'(cout[PL]), 160'(1));
    check("dis_pop", 160'(pop), 160'(0));
    check("dis_out", 160'(dout), 160'(0));
    sb_add(PE, 32'h4350_0042);
    enable = 1'b1;
    tick();
    check("en_east", 160'(dout[PE]), 160'(32'h4350_0042));
    sb_drained("en_sb");

    // Idle words are never written; reset mid-packet clears everything at once.
    do_reset(2'd0, 2'd0);
    din[PL] = 32'h0000_0009; push[PL] = 1'b1;
    tick();
    clear_in();
    check("idle_cnt", 160'(cout[PL]), 160'(0));
    tick();
    check("idle_out", 160'(dout), 160'(0));
    sb_add(PE, 32'h4350_0025);
    din[PL] = 32'h4350_0025; push[PL] = 1'b1;
    tick();
    din[PL] = 32'h8888_8822;
    tick();
    clear_in();
    check("mid_east", 160'(dout[PE]), 160'(32'h4350_0025));
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_out", 160'(dout), 160'(0));
    check("mid_rst_cnt", 160'(cout), 160'(0));
    check("mid_rst_pop", 160'(pop), 160'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    din[PL] = 32'hC030_0024; push[PL] = 1'b1;
    tick();
    clear_in();
    tick();
    check("orphan_pop", 160'(pop[PL]), 160'(1));
    check("orphan_out", 160'(dout), 160'(0));
    tick();
    check("orphan_cnt", 160'(cout[PL]), 160'(0));
    sb_drained("orphan_sb");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/router.md
ROUTER -- requirements
Module: router

Interface
REQ-001 Parameter DEPTH, default 4, input FIFO depth per port in flits; count width 3 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 enable  input  1  high: router operates; low: all state frozen.
REQ-005 routeridx, routeridy  input  2 each  this router's mesh X/Y coordinate.
REQ-006 north_in, south_in, east_in, west_in, local_in  input  32 each  flit data per port.
REQ-007 push_north, push_south, push_east, push_west, push_local  input  1 each  write-strobe for the matching *_in.
REQ-008 count_in_north/south/east/west/local  input  3 each  downstream occupancy seen on that output (0..4).
REQ-009 north_out, south_out, east_out, west_out, local_out  output  32 each  forwarded flit, registered.
REQ-010 count_out_north/south/east/west/local  output  3 each  occupancy of this router's input FIFO for that port.
REQ-011 pop_north/south/east/west/local  output  1 each  one-cycle pulse when a flit leaves that input FIFO.

Function
REQ-012 Flit type = bits[31:30]: 00 idle, 01 header, 10 body, 11 tail; header destination X = bits[23:22], Y = bits[21:20]; bits[29:24], [19:0] payload, passed unchanged.
REQ-013 On each edge with enable=1, push=1, type != 00 and FIFO not full, the input word SHALL be written to that port's FIFO; idle words and writes to a full FIFO SHALL be dropped.
REQ-014 XY routing on header: destX>idx -> east; destX<idx -> west; else destY>idy -> north; destY<idy -> south; else local.
REQ-015 Wormhole: a header granted an output SHALL lock that output to its input until the matching tail is forwarded; body/tail flits follow the lock.
REQ-016 Body/tail at head of an unlocked input SHALL be popped and discarded (pop pulses, nothing forwarded).
REQ-017 Per output, contention among unlocked requesting inputs SHALL be resolved round-robin, priority order north, south, east, west, local, pointer advancing past the last winner.
REQ-018 A flit SHALL be forwarded only if count_in_<output> < DEPTH; otherwise it waits in its FIFO.
REQ-019 Forwarding: at most one flit per input and per output per cycle; forwarded flit appears on *_out after the edge at which it is popped; flit written at edge k is earliest on output after edge k+1.
REQ-020 *_out SHALL be 32'b0 in any cycle in which no flit is forwarded on it.
REQ-021 Simultaneous push and pop on one FIFO SHALL both take effect; count unchanged; a full FIFO with simultaneous pop accepts the push.
REQ-022 count_out_* SHALL equal current FIFO occupancy (0..4); FIFO pointers wrap modulo DEPTH.
REQ-023 enable=0: no writes, no pops, outputs and locks hold their values, pop_* = 0.

Reset
REQ-024 reset=1 SHALL immediately clear all FIFOs, locks, round-robin pointers; all *_out = 0, count_out_* = 0, pop_* = 0.
REQ-025 Reset mid-packet SHALL discard all buffered flits and release all locks; no partial flit after deassertion.

Verification
REQ-026 id(0,0), local_in=32'h4350_0025 header, push_local one cycle, count_in=0 -> east_out=32'h4350_0025 two edges later, pop_local pulse, count_out_local 1 then 0.
REQ-027 id(1,0), local header dest(0,1) (32'h4310_0025) -> west_out; id(0,0) header dest(0,1) -> north_out; id(1,1) header dest(1,1) -> local_out.
REQ-028 Header, body 32'h8888_8822, tail 32'hC030_0024 on local at id(0,0) dest(1,1) -> three consecutive flits on east_out; lock released after tail.
REQ-029 north and local headers both to east same cycle -> one full packet then the other, no interleaving; next contention winner alternates.
REQ-030 push_local held 6 cycles with count_in_east=4 -> count_out_local saturates at 4, extra flits dropped, east_out=0; count_in_east=0 -> 4 flits drain.
REQ-031 push with type 00 (32'h0000_0009) -> no write, count_out unchanged; reset asserted mid-packet -> all outputs/counts 0 immediately.
